// File: rtl/phy_urx.sv
`default_nettype none
// ============================================================================
// Module   : phy_urx
// Brief    : UART receive PHY. Start, 8 data bits MSB first, even parity,
//            stop. Bits are timed from the shared 1 us tick.
// Revision : 1.0 - initial release
// ============================================================================
module phy_urx (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pluse_us,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_err_par,
    output logic       rx_err_frm,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [6:0] C_SMP_START  = 7'd4;
    localparam logic [6:0] C_SMP_PARITY = 7'd82;
    localparam logic [6:0] C_SMP_STOP   = 7'd91;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sync;
    logic       r_rx_d;
    logic       r_live;
    logic       r_armed;
    logic [6:0] r_cnt_us;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_par_bit;
    logic       w_rx_s;
    logic       w_fall;
    logic       w_smp;
    logic [6:0] w_smp_pt;

    assign w_rx_s  = r_sync[1];
    // The synchroniser resets high, so a line already low at release would
    // look like a fresh edge; only arm once a real high has been seen.
    assign w_fall  = r_armed & r_rx_d & ~w_rx_s;
    assign w_smp   = pluse_us & (r_state != S_IDLE) & (r_cnt_us == w_smp_pt);
    assign rx_busy = (r_state != S_IDLE);

    always_comb begin
        w_smp_pt = 7'd0;
        case (r_state)
            S_START:  w_smp_pt = C_SMP_START;
            S_DATA: begin
                case (r_bit_idx)
                    3'd0:    w_smp_pt = 7'd13;
                    3'd1:    w_smp_pt = 7'd22;
                    3'd2:    w_smp_pt = 7'd30;
                    3'd3:    w_smp_pt = 7'd39;
                    3'd4:    w_smp_pt = 7'd48;
                    3'd5:    w_smp_pt = 7'd56;
                    3'd6:    w_smp_pt = 7'd65;
                    default: w_smp_pt = 7'd74;
                endcase
            end
            S_PARITY: w_smp_pt = C_SMP_PARITY;
            S_STOP:   w_smp_pt = C_SMP_STOP;
            default:  w_smp_pt = 7'd0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fall) w_state_nxt = S_START;
            S_START:  if (w_smp) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_smp && (r_bit_idx == 3'd7)) w_state_nxt = S_PARITY;
            S_PARITY: if (w_smp) w_state_nxt = S_STOP;
            S_STOP:   if (w_smp) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_live  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], uart_rx};
            r_rx_d  <= w_rx_s;
            r_live  <= 1'b1;
            if (r_live && r_sync[0]) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_us   <= 7'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_bit  <= 1'b0;
            rx_data    <= 8'h00;
            rx_vld     <= 1'b0;
            rx_err_par <= 1'b0;
            rx_err_frm <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt_us  <= 7'd0;
                r_bit_idx <= 3'd0;
            end else if (pluse_us) begin
                r_cnt_us <= r_cnt_us + 7'd1;
            end
            if (w_smp) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {r_shift[6:0], w_rx_s};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    S_PARITY: r_par_bit <= w_rx_s;
                    S_STOP: begin
                        rx_data    <= r_shift;
                        rx_err_par <= r_par_bit ^ (^r_shift);
                        rx_err_frm <= ~w_rx_s;
                        rx_vld     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
